// File: rtl/transmitter_native.sv
// transmitter_native: UART transmitter fed from a FIFO read port.
// Each word becomes one idle-high asynchronous frame: start bit, WORD_WIDTH
// data bits LSB first, optional even-parity bit, one stop bit.
// Optional feature macro: TRANSMITTER_NATIVE_PARITY_EN (inserts the parity bit).
module transmitter_native #(
  parameter logic [31:0] CLOCK_FREQUENCY = 32'd100_000_000,
  parameter logic [31:0] BAUD_RATE       = 32'd115200,
  parameter logic [31:0] WORD_WIDTH      = 32'd8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] din,
  input  logic                  empty,
  output logic                  re,
  output logic                  dout,
  output logic                  busy
);

  localparam int unsigned CPB = CLOCK_FREQUENCY / BAUD_RATE;
`ifdef TRANSMITTER_NATIVE_PARITY_EN
  localparam int unsigned N = WORD_WIDTH + 3;
`else
  localparam int unsigned N = WORD_WIDTH + 2;
`endif
  localparam int unsigned BW = $clog2(N + 1);

  localparam logic [31:0]   CPB_LAST = 32'(CPB - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

  localparam logic [1:0] STATE_IDLE      = 2'd0;
  localparam logic [1:0] STATE_READ      = 2'd1;
  localparam logic [1:0] STATE_LOAD      = 2'd2;
  localparam logic [1:0] STATE_SEND_BITS = 2'd3;

  logic [1:0]    state;
  logic [N-1:0]  frame;
  logic [BW-1:0] bit_cnt;
  logic [31:0]   clk_cnt;

  // The line is the bottom of the frame register; it is all ones whenever
  // no frame is in flight, so the line idles high without extra muxing.
  assign dout = frame[0];
  assign re   = (state == STATE_READ);
  assign busy = (state != STATE_IDLE);

  // Sequencer and frame shifter: fetch a word, load it, shift it out one
  // bit every CPB cycles, back-filling with ones so the stop bit falls out last.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= STATE_IDLE;
      frame   <= '1;
      bit_cnt <= '0;
      clk_cnt <= '0;
    end else begin
      case (state)
        STATE_IDLE: begin
          if (!empty) state <= STATE_READ;
        end
        STATE_READ: begin
          state <= STATE_LOAD;
        end
        STATE_LOAD: begin
`ifdef TRANSMITTER_NATIVE_PARITY_EN
          frame <= {1'b1, ^din, din, 1'b0};
`else
          frame <= {1'b1, din, 1'b0};
`endif
          bit_cnt <= '0;
          clk_cnt <= '0;
          state   <= STATE_SEND_BITS;
        end
        STATE_SEND_BITS: begin
          if (clk_cnt == CPB_LAST) begin
            clk_cnt <= '0;
            frame   <= {1'b1, frame[N-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) state <= STATE_IDLE;
          end else begin
            clk_cnt <= clk_cnt + 32'd1;
          end
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_transmitter_native.sv
// tb_transmitter_native: directed checks of transmitter_native at 16 clocks
// per bit, 8-bit words; expected frames are hand-written constants and the
// parity build uses its own set (TRANSMITTER_NATIVE_PARITY_EN).
module tb_transmitter_native;

  localparam int CPB = 16;
`ifdef TRANSMITTER_NATIVE_PARITY_EN
  localparam int NB = 11;
  localparam logic [10:0] E_A5 = {1'b1, 1'b0, 8'hA5, 1'b0};
  localparam logic [10:0] E_01 = {1'b1, 1'b1, 8'h01, 1'b0};
  localparam logic [10:0] E_00 = {1'b1, 1'b0, 8'h00, 1'b0};
  localparam logic [10:0] E_FF = {1'b1, 1'b0, 8'hFF, 1'b0};
`else
  localparam int NB = 10;
  localparam logic [10:0] E_A5 = {1'b0, 1'b1, 8'hA5, 1'b0};
  localparam logic [10:0] E_01 = {1'b0, 1'b1, 8'h01, 1'b0};
  localparam logic [10:0] E_00 = {1'b0, 1'b1, 8'h00, 1'b0};
  localparam logic [10:0] E_FF = {1'b0, 1'b1, 8'hFF, 1'b0};
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       empty = 1'b1;
  logic       re, dout, busy;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int re_cnt = 0;
  int re_cyc[$];
  logic [7:0] q[$];

  transmitter_native #(
    .CLOCK_FREQUENCY(32'd16),
    .BAUD_RATE      (32'd1),
    .WORD_WIDTH     (32'd8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .empty(empty),
    .re   (re),
    .dout (dout),
    .busy (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: serve a word the cycle after each read pulse, log pulses.
  always @(negedge clk) begin
    if (re === 1'b1) begin
      re_cnt++;
      re_cyc.push_back(cyc);
      if (q.size() > 0) din = q.pop_front();
    end
    empty = (q.size() == 0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] w);
    q.push_back(w);
    empty = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    int k = 0;
    while (dout !== 1'b0 && k < 60) begin
      step();
      k++;
    end
    ok = (dout === 1'b0);
  endtask

  // Check start latency from t0, then each bit held exactly CPB cycles.
  task automatic check_frame(input string tag, input logic [10:0] exp, input int t0);
    bit ok;
    int hits;
    wait_start(ok);
    if (!ok) begin
      chk({tag, "_start_seen"}, 0, 1);
      return;
    end
    chk({tag, "_start_lat"}, cyc - t0, 3);
    for (int i = 0; i < NB; i++) begin
      hits = 0;
      repeat (CPB) begin
        if (dout === exp[i]) hits++;
        step();
      end
      chk($sformatf("%s_bit%0d", tag, i), hits, CPB);
    end
  endtask

  initial begin
    int c, t0, t1, r0, bad;
    bit ok;

    // Reset held 3 cycles with a word already waiting.
    push(8'hA5);
    repeat (3) begin
      step();
      chk("rst_outputs", {29'd0, dout, re, busy}, 32'b100);
    end
    rst = 1'b0;
    c = cyc;
    check_frame("a5", E_A5, c);
    chk("a5_busy_end", busy, 0);
    chk("a5_dout_end", dout, 1);
    chk("a5_re_count", re_cnt, 1);
    if (re_cyc.size() > 0) chk("rst_first_re", re_cyc[0] - c, 1);
    else chk("rst_first_re_seen", 0, 1);

    // Single word 0x01.
    step();
    r0 = re_cnt;
    push(8'h01);
    t0 = cyc;
    check_frame("w01", E_01, t0);
    chk("w01_busy_end", busy, 0);
    chk("w01_re_count", re_cnt - r0, 1);

    // Back-to-back 0x00 then 0xFF: second start 3 cycles after first stop.
    step();
    r0 = re_cnt;
    push(8'h00);
    push(8'hFF);
    t0 = cyc;
    check_frame("w00", E_00, t0);
    t1 = cyc;
    check_frame("wff", E_FF, t1);
    chk("b2b_busy_end", busy, 0);
    chk("b2b_re_count", re_cnt - r0, 2);
    if (re_cyc.size() >= r0 + 2) chk("b2b_re_gap", re_cyc[r0+1] - re_cyc[r0], NB * CPB + 3);
    else chk("b2b_re_seen", 0, 1);

    // Empty held high: nothing moves.
    r0 = re_cnt;
    bad = 0;
    repeat (500) begin
      step();
      if (re !== 1'b0 || dout !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("idle500_bad", bad, 0);
    chk("idle500_re", re_cnt - r0, 0);

    // Reset in the middle of a 0x3C frame abandons it.
    push(8'h3C);
    wait_start(ok);
    chk("w3c_start_seen", ok, 1);
    repeat (4 * CPB + 5) step();
    rst = 1'b1;
    step();
    chk("midrst_dout", dout, 1);
    chk("midrst_busy", busy, 0);
    rst = 1'b0;
    r0 = re_cnt;
    bad = 0;
    repeat (300) begin
      step();
      if (dout !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("midrst_idle_bad", bad, 0);
    chk("midrst_re", re_cnt - r0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/transmitter_native.md
# transmitter_native

UART transmitter: drains words from an upstream FIFO and serialises each as one asynchronous frame (start bit, WORD_WIDTH data bits LSB first, optional parity bit, one stop bit) on a single idle-high line. It is the transmit-side counterpart of `receiver_native`. It sits between a transmit FIFO's read port and the `txd` pad, and uses the same CLOCK_FREQUENCY/BAUD_RATE bit-timing scheme.

## Interface
- CLOCK_FREQUENCY, 32'd100_000_000, system clock frequency in Hz.
- BAUD_RATE, 32'd115200, line rate in bit/s; CLOCKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE (integer division), must be ≥ 2.
- WORD_WIDTH, 32'd8, data bits per frame.

- clk  input  1  sole clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- din  input  WORD_WIDTH  FIFO read data; valid the cycle after `re` is high.
- empty  input  1  FIFO empty flag.
- re  output  1  FIFO read enable, one-cycle pulse per word.
- dout  output  1  serial line, idle high.
- busy  output  1  high whenever state ≠ STATE_IDLE.

## Operation
- States: STATE_IDLE, STATE_READ, STATE_LOAD, STATE_SEND_BITS.
- STATE_IDLE: if `~empty` → STATE_READ, else stay. dout = 1.
- STATE_READ: `re` = 1 this cycle only; → STATE_LOAD unconditionally.
- STATE_LOAD: capture din into frame shift register {1'b1, [parity], din, 1'b0}; clear bit counter and clock counter; → STATE_SEND_BITS.
- STATE_SEND_BITS: dout = frame[0] (registered). Clock counter counts 0..CLOCKS_PER_BIT-1; at CLOCKS_PER_BIT-1, the counter returns to 0, the frame shifts right with 1 filled in, and the bit counter increments. After the last (stop) bit completes → STATE_IDLE.
- Frame length N = WORD_WIDTH+2 bits (WORD_WIDTH+3 with parity).
- `re` = (state == STATE_READ), combinational from the state register. `re` is never asserted while `empty` was low only in the same cycle. The request is committed on the IDLE→READ transition and the FIFO guarantees the word.
- Illegal state encodings → STATE_IDLE next cycle.
- Reset values: state STATE_IDLE, frame all ones, dout 1, re 0, busy 0, counters 0.
- Reset mid-frame: the next cycle dout = 1 and the frame is abandoned; the word is not re-read.
- `empty` and `din` are ignored outside STATE_IDLE and STATE_LOAD respectively.

## Timing
- Cycle t: IDLE sees empty=0. At t+1: READ, re=1. At t+2: LOAD. At t+3: first SEND cycle, dout = 0 (start bit).
- Each bit is held exactly CLOCKS_PER_BIT cycles. The stop bit ends at t+3+N·CLOCKS_PER_BIT, and the state is IDLE that cycle.
- Back-to-back words: the next start bit begins 3 cycles after the previous stop bit ends, so the idle gap is 3 extra high cycles.
- The bit counter is ⌈log2(N+1)⌉ bits wide and the clock counter is 32 bits; no wrap-around can occur within a frame.

## Configuration
- Macro: TRANSMITTER_NATIVE_PARITY_EN.
- Defined: an even-parity bit (XOR of din) is inserted between the MSB and the stop bit, and N = WORD_WIDTH+3.
- Undefined: there is no parity bit, N = WORD_WIDTH+2, and no parity logic is synthesised.
- Everything else is identical in both builds.

## Test plan
All directed scenarios use CLOCK_FREQUENCY=16, BAUD_RATE=1 (CLOCKS_PER_BIT=16) and WORD_WIDTH=8.
- Reset with empty=0: hold rst 3 cycles → dout=1, re=0, busy=0 throughout reset. The first re pulse occurs 1 cycle after rst deasserts.
- Single word 0xA5 (no parity): dout = 0,1,0,1,0,0,1,0,1,1, each held 16 cycles. The start bit appears 3 cycles after IDLE sees empty=0. Exactly one re pulse.
- FIFO with 0x00 then 0xFF, empty staying low: two frames separated by exactly 3 high cycles. Two re pulses, 163 cycles apart (10·16+3).
- empty held high 500 cycles: re never asserts, dout=1, busy=0.
- rst pulse at bit 4 of a frame of 0x3C: dout=1 the cycle after rst. With empty=1 afterwards, no further re pulse and the line stays idle.
- TRANSMITTER_NATIVE_PARITY_EN defined: 0xA5 → parity bit 0; 0x01 → parity bit 1. Frame is 11 bits (176 cycles).
